// File: rtl/prach_ditfft2_twiddle.sv
// Streaming twiddle multiplier between radix-2 DIT butterfly stages.
// Upper half of each frame is rotated by W_L^j; lower half bypasses.
`timescale 1ns/1ps
module prach_ditfft2_twiddle #(
   parameter int NUM_FFT_LENGTH = 8,
   parameter int TWIDDLE_WIDTH  = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [17:0] din_dr,
   input  logic signed [17:0] din_di,
   input  logic               din_dv,
   input  logic               sync_in,
   input  logic               sync_ahead_in,
   output logic signed [17:0] dout_dr,
   output logic signed [17:0] dout_di,
   output logic               dout_dv,
   output logic               sync_out,
   output logic               sync_ahead_out
);

   localparam int LATENCY = 4;
   localparam int DW   = 18;
   localparam int L    = NUM_FFT_LENGTH;
   localparam int HALF = L / 2;
   localparam int TW   = TWIDDLE_WIDTH;
   localparam int CW   = (L > 2) ? $clog2(L) : 1;
   localparam int JW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int PW   = DW + TW;
   localparam int SW   = PW + 1;
   localparam int FRAC = TW - 2;
   localparam real PI  = 3.14159265358979323846;
   localparam logic signed [SW:0] RND = (SW+1)'(1) <<< (TW - 3);

   // Elaboration-time twiddle value, round-to-nearest (ties away from zero)
   function automatic logic signed [TW-1:0] tw_val(input int j, input logic im);
      real ang;
      real v;
      ang = 2.0 * PI * real'(j) / real'(L);
      v   = im ? -$sin(ang) : $cos(ang);
      v   = v * (2.0 ** FRAC);
      if (v >= 0.0) return TW'($rtoi(v + 0.5));
      return TW'(-$rtoi(0.5 - v));
   endfunction

   function automatic logic signed [DW-1:0] rnd_sat(input logic signed [SW-1:0] v);
      logic signed [SW:0] t;
      t = (SW+1)'(v) + RND;
      t = t >>> FRAC;
      if (t[SW] && !(&t[SW:DW-1])) return {1'b1, {(DW-1){1'b0}}};
      if (!t[SW] && (|t[SW:DW-1])) return {1'b0, {(DW-1){1'b1}}};
      return t[DW-1:0];
   endfunction

   logic signed [TW-1:0] rom_wr [2**JW];
   logic signed [TW-1:0] rom_wi [2**JW];

   for (genvar g = 0; g < 2**JW; g++) begin : g_rom
      localparam logic signed [TW-1:0] WR = tw_val(g, 1'b0);
      localparam logic signed [TW-1:0] WI = tw_val(g, 1'b1);
      assign rom_wr[g] = WR;
      assign rom_wi[g] = WI;
   end

   logic [CW-1:0] cnt;
   logic [CW-1:0] idx;
   logic [JW-1:0] jdx;
   logic          started;
   logic          byp0;

   assign idx  = sync_in ? '0 : (started ? cnt : '0);
   assign jdx  = JW'(idx - CW'(HALF));
   assign byp0 = (idx < CW'(HALF));

   // Counter idles until the first sync, then free-runs across frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         started <= 1'b0;
      end else if (sync_in || started) begin
         started <= 1'b1;
         cnt     <= (idx == CW'(L - 1)) ? '0 : idx + CW'(1);
      end
   end

   logic signed [DW-1:0] x1r, x1i, x2r, x2i, x3r, x3i;
   logic signed [TW-1:0] w1r, w1i;
   logic                 b1, b2, b3;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [SW-1:0] sr, si;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x1r <= '0;
         x1i <= '0;
         w1r <= '0;
         w1i <= '0;
         b1  <= 1'b0;
      end else begin
         x1r <= din_dr;
         x1i <= din_di;
         w1r <= rom_wr[jdx];
         w1i <= rom_wi[jdx];
         b1  <= byp0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
         x2r  <= '0;
         x2i  <= '0;
         b2   <= 1'b0;
      end else begin
         p_rr <= PW'(x1r) * PW'(w1r);
         p_ii <= PW'(x1i) * PW'(w1i);
         p_ri <= PW'(x1r) * PW'(w1i);
         p_ir <= PW'(x1i) * PW'(w1r);
         x2r  <= x1r;
         x2i  <= x1i;
         b2   <= b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         si  <= '0;
         x3r <= '0;
         x3i <= '0;
         b3  <= 1'b0;
      end else begin
         sr  <= SW'(p_rr) - SW'(p_ii);
         si  <= SW'(p_ri) + SW'(p_ir);
         x3r <= x2r;
         x3i <= x2i;
         b3  <= b2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_dr <= '0;
         dout_di <= '0;
      end else begin
         dout_dr <= b3 ? x3r : rnd_sat(sr);
         dout_di <= b3 ? x3i : rnd_sat(si);
      end
   end

   logic [LATENCY-1:0][2:0] sb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb <= '0;
      end else begin
         sb <= {sb[LATENCY-2:0], {sync_ahead_in, sync_in, din_dv}};
      end
   end

   assign {sync_ahead_out, sync_out, dout_dv} = sb[LATENCY-1];

endmodule
